// File: rtl/array_key_scan_if.sv
// Keypad / key-code interface for the 4x4 matrix scanner.
// The scanner (master) drives the column lines and the key_num/key_vld
// strobe. It reads the row lines. The slave side is the keypad itself
// together with the downstream hex-to-decimal converter.
interface array_key_scan_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_num;
  logic       key_vld;

  modport master (
    input  key_row,
    output key_col,
    output key_num,
    output key_vld
  );

  modport slave (
    output key_row,
    input  key_col,
    input  key_num,
    input  key_vld
  );
endinterface

// File: rtl/array_key_scan.sv
// 4x4 active-low matrix keypad scanner.
// It synchronises the row lines, debounces press and release, and scans the
// columns in order 0..3. It emits key_num = {row, col} together with a
// one-cycle key_vld strobe. Priority: first column with a low row, then
// lowest row.
// Optional auto-repeat is enabled by defining the macro KEY_REPEAT_EN.
// With that macro, a held key is rescanned every REPEAT_CYC cycles while it
// stays down.
module array_key_scan #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_SETTLE  = 4,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  array_key_scan_if.master kp
);

  localparam int CNT_MAX = (DEBOUNCE_CYC > SCAN_SETTLE) ? DEBOUNCE_CYC : SCAN_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SCAN_SETTLE - 1);

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYC);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);
`else
  // REPEAT_CYC has no effect without auto-repeat.
  // This reference only keeps the parameter list identical in both builds.
  if (REPEAT_CYC < 1) begin : g_repeat_unused
  end
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    SCAN,
    EMIT,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       key_col_q, key_col_d;
  logic [3:0]       key_num_q, key_num_d;
  logic             key_vld_q, key_vld_d;
  logic [3:0]       sync1_q, rows_q;
  logic             any_low;
  logic [1:0]       low_row;
`ifdef KEY_REPEAT_EN
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign any_low = (rows_q != 4'b1111);

  // Two-flop synchroniser for the asynchronous row lines. It idles high,
  // which matches the state of released keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b1111;
      rows_q  <= 4'b1111;
    end else begin
      sync1_q <= kp.key_row;
      rows_q  <= sync1_q;
    end
  end

  // Lowest-numbered row currently pulled low wins within a column
  always_comb begin
    low_row = 2'd3;
    casez (rows_q)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  end

  // Next-state logic for the scan FSM, its counters and its registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    key_col_d = 4'b0000;
    key_num_d = key_num_q;
    key_vld_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d     = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_low) begin
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!any_low) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          col_d   = 2'd0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCAN: begin
        if (cnt_q == SET_LAST) begin
          cnt_d = '0;
          if (any_low) begin
            row_d   = low_row;
            state_d = EMIT;
          end else if (col_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        key_num_d = {row_q, col_q};
        key_vld_d = 1'b1;
        cnt_d     = '0;
`ifdef KEY_REPEAT_EN
        rpt_d     = '0;
`endif
        state_d   = RELEASE;
      end
      RELEASE: begin
        if (any_low) begin
          cnt_d = '0;
`ifdef KEY_REPEAT_EN
          if (rpt_q == RPT_LAST) begin
            rpt_d   = '0;
            col_d   = 2'd0;
            state_d = SCAN;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end else begin
`ifdef KEY_REPEAT_EN
          rpt_d = '0;
`endif
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (state_d == SCAN) begin
      key_col_d = ~(4'b0001 << col_d);
    end
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      key_col_q <= 4'b0000;
      key_num_q <= 4'd0;
      key_vld_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      key_col_q <= key_col_d;
      key_num_q <= key_num_d;
      key_vld_q <= key_vld_d;
`ifdef KEY_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign kp.key_col = key_col_q;
  assign kp.key_num = key_num_q;
  assign kp.key_vld = key_vld_q;

endmodule

// File: tb/tb_array_key_scan.sv
// Self-checking bench for array_key_scan.
// An ideal keypad model turns a 16-bit pressed-key mask into row levels,
// based on the columns being driven. Each press is checked for pulse count,
// key code, latency and the column-drive sequence. The expected values come
// from the priority rule applied directly to the mask.
module tb_array_key_scan;
  localparam int DEB = 8;
  localparam int SET = 3;
  localparam int RPT = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pressed;
  logic [3:0]  row_lines;

  array_key_scan_if kp ();

  array_key_scan #(
    .DEBOUNCE_CYC(DEB),
    .SCAN_SETTLE (SET),
    .REPEAT_CYC  (RPT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Ideal matrix: a row reads low if any pressed key on it sits in a driven column
  always_comb begin
    row_lines = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.key_col[c]) row_lines[r] = 1'b0;
  end
  assign kp.key_row = row_lines;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int         pulse_cyc[$];
  logic [3:0] pulse_code[$];
  logic [3:0] col_hist[$];
  logic       prev_vld = 1'b0;
  logic [3:0] last_num = 4'd0;
  logic [3:0] prev_col = 4'd0;

  // Output monitor: records pulses and column changes, checks strobe spacing and key_num hold
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      last_num = 4'd0;
      prev_col = 4'd0;
    end else begin
      if (kp.key_vld) begin
        checks++;
        if (prev_vld) begin
          errors++;
          $display("[TB] FAIL vld_back_to_back: key_vld high two cycles in a row at cycle %0d", cyc);
        end
        pulse_cyc.push_back(cyc);
        pulse_code.push_back(kp.key_num);
        last_num = kp.key_num;
      end else begin
        checks++;
        if (kp.key_num !== last_num) begin
          errors++;
          $display("[TB] FAIL num_hold: key_num=%0d expected held value %0d", kp.key_num, last_num);
          last_num = kp.key_num;
        end
      end
      if (kp.key_col !== prev_col) col_hist.push_back(kp.key_col);
      prev_col = kp.key_col;
      prev_vld = kp.key_vld;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Reference rule: first column holding any key, then lowest row in it
  function automatic int modelCode(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4+c]) return r*4 + c;
    return 0;
  endfunction

  task automatic clearRecords();
    pulse_cyc.delete();
    pulse_code.delete();
    col_hist.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int hold);
    pressed = mask;
    repeat (hold) @(negedge clk);
    pressed = '0;
  endtask

  task automatic runVector(input string tag, input logic [15:0] mask, input int hold,
                           input int exp_pulses, input int exp_code);
    int press_cyc;
    int c;
    int exp_lat;
    int exp_col;
    clearRecords();
    @(negedge clk);
    press_cyc = cyc;
    applyStimulus(mask, hold);
    repeat (30) @(negedge clk);
    checkOutput({tag, " pulses"}, pulse_cyc.size(), exp_pulses);
    if (exp_pulses > 0 && pulse_cyc.size() > 0) begin
      checkOutput({tag, " code"}, pulse_code[0], exp_code);
      c       = exp_code % 4;
      exp_lat = 2 + DEB + (c + 1) * SET + 1;
      checkRange({tag, " latency"}, pulse_cyc[0] - press_cyc, exp_lat - 2, exp_lat + 2);
      checkOutput({tag, " col steps"}, col_hist.size(), c + 2);
      for (int k = 0; k < col_hist.size(); k++) begin
        exp_col = (k <= c) ? ((~(1 << k)) & 15) : 0;
        checkOutput({tag, " col value"}, col_hist[k], exp_col);
      end
    end else if (exp_pulses == 0) begin
      checkOutput({tag, " col steps"}, col_hist.size(), 0);
    end
  endtask

  typedef struct {
    string       tag;
    logic [15:0] mask;
    int          hold;
    int          exp_pulses;
    int          exp_code;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         waited;
    int         n;
    logic [15:0] m;
    int         h;
    int         last_pulse;

    pressed = '0;
    rst_n   = 1'b0;
    #3;
    checkOutput("reset key_col", kp.key_col, 0);
    checkOutput("reset key_num", kp.key_num, 0);
    checkOutput("reset key_vld", kp.key_vld, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{"r1c2",         16'h0040, 40, 1, 6};
    vecs[1] = '{"bounce",       16'h0001,  5, 0, 0};
    vecs[2] = '{"two keys",     16'h0802, 40, 1, 1};
    vecs[3] = '{"rel after c0", 16'h1000, 15, 1, 12};
    vecs[4] = '{"rel in db",    16'h0001,  8, 0, 0};
    vecs[5] = '{"r3c3",         16'h8000, 40, 1, 15};
    vecs[6] = '{"col0 multi",   16'h0130, 40, 1, 4};
    vecs[7] = '{"r0c3",         16'h0008, 40, 1, 3};
    for (int i = 0; i < 8; i++)
      runVector(vecs[i].tag, vecs[i].mask, vecs[i].hold, vecs[i].exp_pulses, vecs[i].exp_code);

    for (int i = 0; i < 12; i++) begin
      m = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) m = m | 16'(1 << $urandom_range(0, 15));
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(30, 45);
      runVector("random", m, h, (h >= 30) ? 1 : 0, modelCode(m));
    end

    // Short release gap is absorbed by the release debounce
    clearRecords();
    @(negedge clk);
    applyStimulus(16'h0040, 40);
    repeat (4) @(negedge clk);
    applyStimulus(16'h0040, 30);
    repeat (30) @(negedge clk);
    checkOutput("regrab pulses", pulse_cyc.size(), 1);

    // Extra key kept down after the first is released: still one pulse
    clearRecords();
    @(negedge clk);
    pressed = 16'h0802;
    repeat (25) @(negedge clk);
    pressed = 16'h0800;
    repeat (10) @(negedge clk);
    pressed = '0;
    repeat (30) @(negedge clk);
    checkOutput("partial release pulses", pulse_cyc.size(), 1);
    if (pulse_code.size() > 0) checkOutput("partial release code", pulse_code[0], 1);

    // Asynchronous reset in the middle of a scan
    clearRecords();
    @(negedge clk);
    pressed = 16'h0008;
    waited  = 0;
    while (kp.key_col !== 4'b1011 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reach scan col2", (kp.key_col === 4'b1011) ? 1 : 0, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midscan reset key_col", kp.key_col, 0);
    checkOutput("midscan reset key_vld", kp.key_vld, 0);
    checkOutput("midscan reset key_num", kp.key_num, 0);
    pressed = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midscan reset pulses", pulse_cyc.size(), 0);
    runVector("after reset", 16'h0040, 40, 1, 6);

    // Long hold of row3/col3
    clearRecords();
    @(negedge clk);
    pressed = 16'h8000;
    repeat (200) @(negedge clk);
    pressed = '0;
    last_pulse = cyc + 5;
    repeat (60) @(negedge clk);
    n = pulse_cyc.size();
`ifdef KEY_REPEAT_EN
    checkRange("repeat pulses", n, 3, 5);
    for (int k = 0; k < n; k++) checkOutput("repeat code", pulse_code[k], 15);
    for (int k = 1; k < n; k++)
      checkRange("repeat spacing", pulse_cyc[k] - pulse_cyc[k-1], RPT + 4*SET - 4, RPT + 4*SET + 8);
`else
    checkOutput("long hold pulses", n, 1);
    if (n > 0) checkOutput("long hold code", pulse_code[0], 15);
`endif
    if (n > 0) checkRange("no pulse after release", pulse_cyc[n-1], 0, last_pulse);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
